// File: rtl/display_arbiter.sv
// Purpose: round-robin arbiter granting one of three requesters the 4-digit seven-segment display.
// Latency: 1 cycle from sampled req to grant/big_bin; each grant lasts at least HOLD_TICKS tick pulses.
// Backpressure: none; requests are level-sensitive and simply wait, and a grant is never preempted.
module display_arbiter #(
    parameter int unsigned HOLD_TICKS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic [2:0]  req,
    input  logic [19:0] frame0,
    input  logic [19:0] frame1,
    input  logic [19:0] frame2,
    output logic [2:0]  grant,
    output logic [19:0] big_bin,
    output logic        done,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HOLD    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    // Four dash glyphs (code 18) shown whenever nobody owns the display.
    localparam logic [19:0] DASHES = 20'h94A52;

    // The counter holds ticks already seen; the tick that would bring it to
    // HOLD_TICKS is the expiry tick, so we compare against HOLD_TICKS-1 and
    // decide on that same cycle instead of one cycle later.
    localparam logic [7:0]  HOLD_LAST = 8'(HOLD_TICKS - 1);

    // Codes above 19 are not drawable glyphs; show them as blank (19).
    function automatic logic [4:0] clean_glyph(input logic [4:0] code);
        return (code > 5'd19) ? 5'd19 : code;
    endfunction

    function automatic logic [19:0] clean_frame(input logic [19:0] f);
        logic [19:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*5 +: 5] = clean_glyph(f[i*5 +: 5]);
        end
        return r;
    endfunction

    // Round-robin search starting just after the last owner.
    // Result is {found, index}.
    function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] idx;
        logic       found;
        logic [2:0] res;
        res   = 3'b000;
        found = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            idx = 2'((int'(last) + k) % 3);
            if (!found && r[idx]) begin
                found = 1'b1;
                res   = {1'b1, idx};
            end
        end
        return res;
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  grant_q, grant_d;
    logic [1:0]  gidx_q, gidx_d;
    logic [19:0] big_bin_q, big_bin_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  last_q, last_d;

    logic [2:0]  pick;
    logic        win_vld;
    logic [1:0]  win_idx;
    logic [19:0] win_frame;
    logic [19:0] own_frame;
    logic        own_req;
    logic        other_req;

    assign pick    = rr_pick(req, last_q);
    assign win_vld = pick[2];
    assign win_idx = pick[1:0];

    // Frame of the round-robin winner, already sanitised.
    always_comb begin
        win_frame = clean_frame(frame0);
        case (win_idx)
            2'd1:    win_frame = clean_frame(frame1);
            2'd2:    win_frame = clean_frame(frame2);
            default: win_frame = clean_frame(frame0);
        endcase
    end

    // Frame of the current owner, already sanitised.
    always_comb begin
        own_frame = clean_frame(frame0);
        case (gidx_q)
            2'd1:    own_frame = clean_frame(frame1);
            2'd2:    own_frame = clean_frame(frame2);
            default: own_frame = clean_frame(frame0);
        endcase
    end

    assign own_req   = req[gidx_q];
    assign other_req = |(req & ~grant_q);

    // State and datapath registers; reset drops the grant at once without a done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            grant_q   <= 3'b000;
            gidx_q    <= 2'd0;
            big_bin_q <= DASHES;
            cnt_q     <= 8'd0;
            last_q    <= 2'd2;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            big_bin_q <= big_bin_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
        end
    end

    // Next-state logic: arbitration, hold timing, and display loading.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        big_bin_d = big_bin_q;
        cnt_d     = cnt_q;
        last_d    = last_q;

        case (state_q)
            S_IDLE: begin
                big_bin_d = DASHES;
                if (win_vld) begin
                    state_d   = S_HOLD;
                    grant_d   = 3'b001 << win_idx;
                    gidx_d    = win_idx;
                    big_bin_d = win_frame;
                    cnt_d     = 8'd0;
                end
            end

            S_HOLD: begin
                // Track the owner's frame while it keeps asking; freeze otherwise.
                if (own_req) begin
                    big_bin_d = own_frame;
                end
                if (tick) begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d = 8'd0;
                        // Hand over if anyone else waits or the owner has gone;
                        // a lone persistent owner simply renews its hold.
                        if (other_req || !own_req) begin
                            state_d = S_RELEASE;
                            grant_d = 3'b000;
                            last_d  = gidx_q;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            S_RELEASE: begin
                if (win_vld) begin
                    state_d   = S_HOLD;
                    grant_d   = 3'b001 << win_idx;
                    gidx_d    = win_idx;
                    big_bin_d = win_frame;
                    cnt_d     = 8'd0;
                end else begin
                    state_d   = S_IDLE;
                    big_bin_d = DASHES;
                end
            end

            default: begin
                state_d   = S_IDLE;
                grant_d   = 3'b000;
                big_bin_d = DASHES;
                cnt_d     = 8'd0;
            end
        endcase
    end

    assign grant   = grant_q;
    assign big_bin = big_bin_q;
    assign done    = (state_q == S_RELEASE);
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_display_arbiter.sv
// Purpose: scoreboard bench for display_arbiter with HOLD_TICKS=3 and a tick every 4 cycles.
// Latency: expected grant/done events are queued ahead of stimulus and matched in order.
// Backpressure: not applicable; every wait on the DUT is bounded by a cycle budget.
module tb_display_arbiter;

    localparam logic [19:0] DASHES = 20'h94A52;
    localparam logic [19:0] F0     = 20'h00001;
    localparam logic [19:0] F1     = 20'h0018C;
    localparam logic [19:0] F2     = 20'h00842;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic [2:0]  req;
    logic [19:0] frame0, frame1, frame2;
    logic [2:0]  grant;
    logic [19:0] big_bin;
    logic        done;
    logic        busy;

    display_arbiter #(.HOLD_TICKS(3)) dut (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .req     (req),
        .frame0  (frame0),
        .frame1  (frame1),
        .frame2  (frame2),
        .grant   (grant),
        .big_bin (big_bin),
        .done    (done),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  g;
        logic        d;
        logic [19:0] bb;
    } ev_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    ev_t  exp_q[$];
    chk_t chk_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   tcnt  = 0;

    // Tick generator: one pulse every 4 cycles, changed just after the rising edge.
    initial begin
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tcnt = tcnt + 1;
            tick = (tcnt % 4 == 0);
        end
    end

    task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
        chk_t c;
        c.name = nm;
        c.act  = a;
        c.exp  = e;
        chk_q.push_back(c);
    endtask

    task automatic expect_ev(input logic [2:0] g, input logic d, input logic [19:0] bb);
        ev_t e;
        e.g  = g;
        e.d  = d;
        e.bb = bb;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string nm, input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check({nm, "_timeout_pending"}, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Monitor: all comparisons happen here. Direct checks are drained first,
    // then any grant change or done pulse is matched against the next expected event.
    initial begin
        logic [2:0] prev_g;
        ev_t        e;
        chk_t       c;
        prev_g = 3'b000;
        forever begin
            @(negedge clk);
            while (chk_q.size() != 0) begin
                c = chk_q.pop_front();
                n_cmp++;
                if (c.act !== c.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %h want %h", c.name, c.act, c.exp);
                end
            end
            if (grant !== prev_g || done === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event: got grant=%b done=%b big_bin=%h want no event",
                             grant, done, big_bin);
                end else begin
                    e = exp_q.pop_front();
                    if (grant !== e.g || done !== e.d || big_bin !== e.bb || !$onehot0(grant)) begin
                        n_bad++;
                        $display("FAIL event: got grant=%b done=%b big_bin=%h want grant=%b done=%b big_bin=%h",
                                 grant, done, big_bin, e.g, e.d, e.bb);
                    end
                end
            end
            prev_g = grant;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got no end of stimulus want finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

    // Stimulus.
    initial begin
        logic [19:0] mix_in, mix_out;
        int          ticks, n;

        reset  = 1'b0;
        req    = 3'b000;
        frame0 = '0;
        frame1 = '0;
        frame2 = '0;

        // Reset state, then 20 idle cycles.
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_big_bin", 32'(big_bin), 32'(DASHES));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_big_bin", 32'(big_bin), 32'(DASHES));
            check("idle_grant", 32'(grant), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end

        // Single requester: 1-cycle grant latency, renewals without done, release after drop.
        frame0 = F0;
        expect_ev(3'b001, 1'b0, F0);
        req = 3'b001;
        @(negedge clk);
        check("single_lat_grant", 32'(grant), 32'b001);
        check("single_lat_big_bin", 32'(big_bin), 32'(F0));
        check("single_busy", 32'(busy), 32'd1);
        repeat (30) @(negedge clk);
        check("single_renew_grant", 32'(grant), 32'b001);
        req = 3'b000;
        expect_ev(3'b000, 1'b1, F0);
        wait_drain("single", 60);
        repeat (2) @(negedge clk);
        check("single_idle_big_bin", 32'(big_bin), 32'(DASHES));
        check("single_idle_busy", 32'(busy), 32'd0);

        // Round-robin with all three requesting from a fresh reset.
        pulse_reset();
        frame0 = F0;
        frame1 = F1;
        frame2 = F2;
        expect_ev(3'b001, 1'b0, F0);
        expect_ev(3'b000, 1'b1, F0);
        expect_ev(3'b010, 1'b0, F1);
        expect_ev(3'b000, 1'b1, F1);
        expect_ev(3'b100, 1'b0, F2);
        expect_ev(3'b000, 1'b1, F2);
        expect_ev(3'b001, 1'b0, F0);
        req = 3'b111;
        wait_drain("rr", 200);
        expect_ev(3'b000, 1'b1, F0);
        req = 3'b000;
        wait_drain("rr_end", 40);
        repeat (2) @(negedge clk);

        // Minimum hold: one-cycle request still owns the display for 3 ticks, frozen frame.
        frame1 = F1;
        expect_ev(3'b010, 1'b0, F1);
        expect_ev(3'b000, 1'b1, F1);
        req = 3'b010;
        @(negedge clk);
        req    = 3'b000;
        frame1 = 20'h00421;
        ticks  = 0;
        n      = 0;
        while (done !== 1'b1 && n < 60) begin
            if (grant === 3'b010 && tick === 1'b1) ticks++;
            @(negedge clk);
            n++;
        end
        check("min_hold_ticks", 32'(ticks), 32'd3);
        wait_drain("min_hold", 10);
        @(negedge clk);
        check("min_hold_idle_big_bin", 32'(big_bin), 32'(DASHES));

        // Glyph sanitising, including reload while the owner keeps requesting.
        frame0 = 20'hFFFFF;
        expect_ev(3'b001, 1'b0, 20'h9CE73);
        req = 3'b001;
        @(negedge clk);
        check("sanitize_all", 32'(big_bin), 32'h9CE73);
        mix_in  = {5'd20, 5'd19, 5'd0, 5'd31};
        mix_out = {5'd19, 5'd19, 5'd0, 5'd19};
        frame0  = mix_in;
        @(negedge clk);
        check("sanitize_mix", 32'(big_bin), 32'(mix_out));
        req = 3'b000;
        expect_ev(3'b000, 1'b1, mix_out);
        wait_drain("sanitize", 60);
        repeat (2) @(negedge clk);

        // Reset in the middle of a hold: immediate drop, dashes, no done.
        pulse_reset();
        frame1 = F1;
        expect_ev(3'b010, 1'b0, F1);
        req = 3'b010;
        repeat (3) @(negedge clk);
        check("midhold_grant", 32'(grant), 32'b010);
        check("midhold_busy", 32'(busy), 32'd1);
        expect_ev(3'b000, 1'b0, DASHES);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("async_grant", 32'(grant), 32'd0);
        check("async_big_bin", 32'(big_bin), 32'(DASHES));
        check("async_busy", 32'(busy), 32'd0);
        check("async_done", 32'(done), 32'd0);
        repeat (5) @(negedge clk);
        req   = 3'b000;
        reset = 1'b1;
        wait_drain("midhold", 5);
        repeat (3) @(negedge clk);

        check("leftover_events", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
